// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - default ESC timing constants and command saturation helper
package esc_pkg;

  localparam int DEF_MIN_PULSE = 50000;
  localparam int DEF_SCALE     = 3;
  localparam int DEF_WDOG_FRM  = 8;

  function automatic int sat_comp(input int sum, input int max_val);
    if (sum < 0) return 0;
    if (sum > max_val) return max_val;
    return sum;
  endfunction

endpackage

// File: rtl/esc_chan.sv
// rtl/esc_chan.sv - one ESC channel: active command regs, offset saturation, pulse compare
module esc_chan
  import esc_pkg::*;
#(
  parameter int SPD_W     = 11,
  parameter int OFF_W     = 10,
  parameter int PERIOD_W  = 18,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SPD_W-1:0]    spd_sh,
  input  logic [OFF_W-1:0]    off_sh,
  input  logic                trip,
  input  logic                en,
  input  logic [PERIOD_W-1:0] cnt,
  output logic                pwm
);

  localparam int SUM_W   = SPD_W + 2;
  localparam int SPD_MAX = (1 << SPD_W) - 1;

  logic        [SPD_W-1:0]    spd_act;
  logic signed [OFF_W-1:0]    off_act;
  logic signed [SUM_W-1:0]    sum;
  logic        [SPD_W-1:0]    comp;
  logic        [PERIOD_W-1:0] width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_act <= '0;
      off_act <= '0;
    end else if (load) begin
      spd_act <= spd_sh;
      off_act <= off_sh;
    end
  end

  // Two guard bits keep the signed sum exact before clamping to the speed range.
  always_comb begin
    sum   = $signed({2'b00, spd_act}) + SUM_W'(off_act);
    comp  = trip ? '0 : SPD_W'(sat_comp(int'(sum), SPD_MAX));
    width = PERIOD_W'(MIN_PULSE + int'(comp) * SCALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= (cnt < width) && en;
  end

endmodule

// File: rtl/esc_pwm_array.sv
// rtl/esc_pwm_array.sv - N-channel ESC pulse generator with frame-aligned updates and watchdog
module esc_pwm_array
  import esc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int SPD_W     = 11,
  parameter int OFF_W     = 10,
  parameter int PERIOD_W  = 18,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE,
  parameter int WDOG_FRM  = DEF_WDOG_FRM
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic [NUM_CH*OFF_W-1:0] off,
  input  logic                    spd_vld,
  input  logic                    motors_off,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    frame_strt,
  output logic                    wdog_trip
);

  localparam int WD_W = $clog2(WDOG_FRM + 1);

  if (MIN_PULSE + ((1 << SPD_W) - 1) * SCALE >= (1 << PERIOD_W)) begin : g_width_chk
    $error("esc_pwm_array: maximum pulse width does not fit in the frame");
  end

  logic [PERIOD_W-1:0]     cnt;
  logic                    cnt_zero;
  logic                    pending;
  logic                    kill;
  logic                    load;
  logic                    pwm_en;
  logic [WD_W-1:0]         wd_cnt;
  logic [NUM_CH*SPD_W-1:0] spd_sh;
  logic [NUM_CH*OFF_W-1:0] off_sh;

  assign cnt_zero = (cnt == '0);
  assign load     = cnt_zero && pending;
  // Let the pulse start on the boundary where kill releases, so no runt appears.
  assign pwm_en   = !kill || (cnt_zero && !motors_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      frame_strt <= 1'b0;
      pending    <= 1'b0;
      spd_sh     <= '0;
      off_sh     <= '0;
      wd_cnt     <= '0;
      wdog_trip  <= 1'b0;
      kill       <= 1'b0;
    end else begin
      cnt        <= cnt + PERIOD_W'(1);
      frame_strt <= cnt_zero;
      if (spd_vld) begin
        spd_sh <= spd;
        off_sh <= off;
      end
      // A capture on the boundary clock survives the clear and loads next frame.
      if (spd_vld)       pending <= 1'b1;
      else if (cnt_zero) pending <= 1'b0;
      if (cnt_zero) begin
        if (pending) begin
          wd_cnt    <= '0;
          wdog_trip <= 1'b0;
        end else begin
          if (wd_cnt != WD_W'(WDOG_FRM)) wd_cnt <= wd_cnt + WD_W'(1);
          if (wd_cnt == WD_W'(WDOG_FRM - 1)) wdog_trip <= 1'b1;
        end
      end
      if (motors_off)    kill <= 1'b1;
      else if (cnt_zero) kill <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    esc_chan #(
      .SPD_W    (SPD_W),
      .OFF_W    (OFF_W),
      .PERIOD_W (PERIOD_W),
      .MIN_PULSE(MIN_PULSE),
      .SCALE    (SCALE)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .spd_sh(spd_sh[i*SPD_W +: SPD_W]),
      .off_sh(off_sh[i*OFF_W +: OFF_W]),
      .trip  (wdog_trip),
      .en    (pwm_en),
      .cnt   (cnt),
      .pwm   (pwm[i])
    );
  end

endmodule
